// File: rtl/mac_sequencer.sv
// Initiator for the start/ready MAC handshake: buffers operand pairs, issues a
// commanded batch one operation at a time and reports the accumulator delta.
module mac_sequencer #(
    parameter int unsigned opsize      = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned LOW_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [opsize-1:0]     in_a,
    input  logic [opsize-1:0]     in_b,
    input  logic                  go,
    input  logic [CNT_W-1:0]      batch_len,
    output logic                  busy,
    output logic                  done,
    output logic [2*opsize-1:0]   result,
    output logic                  err,
    output logic [CNT_W-1:0]      issued,
    output logic                  mac_start,
    output logic [opsize-1:0]     mac_a,
    output logic [opsize-1:0]     mac_b,
    input  logic                  mac_ready,
    input  logic [2*opsize-1:0]   mac_out
);

    localparam int unsigned RES_W   = 2 * opsize;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned FCNT_W  = PTR_W + 1;
    localparam int unsigned TMR_W   = $clog2(LOW_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_DONE
    } state_e;

    state_e             state_q,     state_d;
    logic [RES_W-1:0]   mem_q [DEPTH];
    logic [RES_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [FCNT_W-1:0]  fcnt_q,      fcnt_d;
    logic               in_ready_q,  in_ready_d;
    logic [RES_W-1:0]   base_q,      base_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [TMR_W-1:0]   timer_q,     timer_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic [RES_W-1:0]   result_q,    result_d;
    logic               err_q,       err_d;
    logic [CNT_W-1:0]   issued_q,    issued_d;
    logic               mac_start_q, mac_start_d;
    logic [opsize-1:0]  mac_a_q,     mac_a_d;
    logic [opsize-1:0]  mac_b_q,     mac_b_d;
    logic               push;
    logic               pop;

    // Next-state, FIFO and output computation.
    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fcnt_d      = fcnt_q;
        base_d      = base_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        err_d       = err_q;
        issued_d    = issued_q;
        mac_start_d = 1'b0;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        push        = in_valid && in_ready_q;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    issued_d = '0;
                    err_d    = 1'b0;
                    if (batch_len != '0) begin
                        base_d      = mac_out;
                        remaining_d = batch_len;
                        busy_d      = 1'b1;
                        state_d     = S_FETCH;
                    end else begin
                        done_d   = 1'b1;
                        result_d = '0;
                    end
                end
            end
            S_FETCH: begin
                // Also covers a responder still finishing work from before a reset.
                if ((fcnt_q != '0) && mac_ready) begin
                    pop         = 1'b1;
                    mac_a_d     = mem_q[rd_ptr_q][RES_W-1:opsize];
                    mac_b_d     = mem_q[rd_ptr_q][opsize-1:0];
                    mac_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!mac_ready) begin
                    state_d = S_WAIT_HIGH;
                end else if (timer_q == TMR_W'(LOW_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (mac_ready) begin
                    issued_d    = issued_q + CNT_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    state_d     = (remaining_q == CNT_W'(1)) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                result_d = mac_out - base_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = {in_a, in_b};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
        end else if (!push && pop) begin
            fcnt_d = fcnt_q - FCNT_W'(1);
        end
        in_ready_d = (fcnt_d != FCNT_W'(DEPTH));
    end

    // State and output registers; reset abandons the batch and flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
            in_ready_q  <= 1'b1;
            base_q      <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
            issued_q    <= '0;
            mac_start_q <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
            in_ready_q  <= in_ready_d;
            base_q      <= base_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            err_q       <= err_d;
            issued_q    <= issued_d;
            mac_start_q <= mac_start_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign err       = err_q;
    assign issued    = issued_q;
    assign mac_start = mac_start_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural MAC responder.
module tb_mac_sequencer;

    localparam int unsigned OPW = 8;
    localparam int unsigned RW  = 16;
    localparam int unsigned CW  = 8;
    localparam int unsigned LTO = 4;
    localparam int unsigned LAT = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_a;
    logic [OPW-1:0] in_b;
    logic           go;
    logic [CW-1:0]  batch_len;
    logic           busy;
    logic           done;
    logic [RW-1:0]  result;
    logic           err;
    logic [CW-1:0]  issued;
    logic           mac_start;
    logic [OPW-1:0] mac_a;
    logic [OPW-1:0] mac_b;
    logic           mac_ready;
    logic [RW-1:0]  mac_out;

    int n_err    = 0;
    int n_checks = 0;

    mac_sequencer #(
        .opsize(OPW), .DEPTH(4), .CNT_W(CW), .LOW_TIMEOUT(LTO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .go(go), .batch_len(batch_len),
        .busy(busy), .done(done), .result(result), .err(err), .issued(issued),
        .mac_start(mac_start), .mac_a(mac_a), .mac_b(mac_b),
        .mac_ready(mac_ready), .mac_out(mac_out)
    );

    always #5 clk = ~clk;

    // Responder: accepts start while ready, drops ready for LAT cycles, then
    // accumulates. It has no reset of its own; 'stuck' ignores starts entirely.
    logic           stuck     = 1'b0;
    logic           rsp_ready = 1'b1;
    logic [RW-1:0]  acc       = '0;
    logic [3:0]     rcnt      = '0;
    logic [OPW-1:0] ra        = '0;
    logic [OPW-1:0] rb        = '0;

    always @(posedge clk) begin
        if (rsp_ready) begin
            if (mac_start && !stuck) begin
                rsp_ready <= 1'b0;
                rcnt      <= 4'(LAT);
                ra        <= mac_a;
                rb        <= mac_b;
            end
        end else if (rcnt == 4'd1) begin
            acc       <= acc + RW'(ra) * RW'(rb);
            rsp_ready <= 1'b1;
        end else begin
            rcnt <= rcnt - 4'd1;
        end
    end

    assign mac_ready = rsp_ready;
    assign mac_out   = acc;

    // Start monitor: total starts, starts issued against a busy responder, operand log.
    int            start_total    = 0;
    int            start_lowready = 0;
    logic [RW-1:0] ops_q[$];

    always @(posedge clk) begin
        if (mac_start) begin
            start_total <= start_total + 1;
            if (!mac_ready) start_lowready <= start_lowready + 1;
            ops_q.push_back({mac_a, mac_b});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_pair(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("push_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic start_batch(input logic [CW-1:0] n);
        go        = 1'b1;
        batch_len = n;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_done"}, 32'(done), 1);
    endtask

    task automatic run_batch(input string tag, input logic [CW-1:0] n,
                             input logic [RW-1:0] exp_res);
        int s0;
        s0 = start_total;
        start_batch(n);
        wait_done(tag);
        check_eq({tag, "_result"}, 32'(result), 32'(exp_res));
        check_eq({tag, "_issued"}, 32'(issued), 32'(n));
        check_eq({tag, "_busy"},   32'(busy), 0);
        check_eq({tag, "_starts"}, 32'(start_total - s0), 32'(n));
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int qb, s0, k, c_rdy, c_st, c_dn;
        logic drop;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; go = 1'b0; batch_len = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_mac_start", 32'(mac_start), 0);
        check_eq("rst_mac_ab",    32'({mac_a, mac_b}), 0);
        check_eq("rst_busy",      32'(busy), 0);
        check_eq("rst_done",      32'(done), 0);
        check_eq("rst_result",    32'(result), 0);
        check_eq("rst_err",       32'(err), 0);
        check_eq("rst_issued",    32'(issued), 0);
        check_eq("rst_in_ready",  32'(in_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        // Normal batch: 3*4 + 5*6 = 42.
        qb = ops_q.size();
        push_pair(8'd3, 8'd4);
        push_pair(8'd5, 8'd6);
        run_batch("b1", 8'd2, 16'h002A);
        check_eq("b1_nops", 32'(ops_q.size() - qb), 2);
        check_eq("b1_op0",  32'(ops_q[qb]),     32'h0304);
        check_eq("b1_op1",  32'(ops_q[qb + 1]), 32'h0506);

        // Second batch on top of the running accumulator.
        push_pair(8'd3, 8'd4);
        push_pair(8'd5, 8'd6);
        run_batch("b2", 8'd2, 16'h002A);
        check_eq("b2_mac_out", 32'(mac_out), 32'h0054);

        // 2 * 255*255 = 130050 wraps to 0xFC02.
        push_pair(8'd255, 8'd255);
        push_pair(8'd255, 8'd255);
        run_batch("wrap", 8'd2, 16'hFC02);

        // Zero-length batch: done next cycle, result and issued cleared.
        s0 = start_total;
        start_batch(8'd0);
        check_eq("len0_done",   32'(done), 1);
        check_eq("len0_result", 32'(result), 0);
        check_eq("len0_issued", 32'(issued), 0);
        check_eq("len0_busy",   32'(busy), 0);
        @(negedge clk);
        check_eq("len0_pulse",  32'(done), 0);
        check_eq("len0_starts", 32'(start_total - s0), 0);

        // FIFO full: four pushes fill it, the fifth waits for the first pop.
        qb = ops_q.size();
        push_pair(8'd1, 8'd2);
        push_pair(8'd3, 8'd4);
        push_pair(8'd5, 8'd6);
        push_pair(8'd7, 8'd8);
        check_eq("full_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd10;
        s0 = start_total;
        go = 1'b1; batch_len = 8'd5;
        @(negedge clk);
        go = 1'b0;
        k = 0; c_rdy = -1; c_st = -1; drop = 1'b0;
        while (!done && k < 400) begin
            if (drop) begin
                in_valid = 1'b0;
                drop     = 1'b0;
            end
            if (in_valid && in_ready && c_rdy < 0) begin
                c_rdy = k;
                drop  = 1'b1;
            end
            if (mac_start && c_st < 0) c_st = k;
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        check_eq("full_done",       32'(done), 1);
        check_eq("full_pop_seen",   32'(c_st >= 0), 1);
        check_eq("full_fifth_cyc",  32'(c_rdy), 32'(c_st));
        check_eq("full_result",     32'(result), 32'h00BE);
        check_eq("full_issued",     32'(issued), 5);
        check_eq("full_starts",     32'(start_total - s0), 5);
        check_eq("full_nops",       32'(ops_q.size() - qb), 5);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("full_op%0d", i), 32'(ops_q[qb + i]),
                     32'({8'(2 * i + 1), 8'(2 * i + 2)}));
        end
        @(negedge clk);

        // Timeout: responder never drops ready.
        stuck = 1'b1;
        push_pair(8'd1, 8'd1);
        push_pair(8'd1, 8'd1);
        push_pair(8'd1, 8'd1);
        s0 = start_total;
        start_batch(8'd3);
        k = 0; c_st = -1; c_dn = -1;
        while (c_dn < 0 && k < 400) begin
            if (mac_start && c_st < 0) c_st = k;
            if (done) c_dn = k;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check_eq("to_done",    32'(done), 1);
        check_eq("to_latency", 32'(c_dn - c_st), 32'(LTO + 2));
        check_eq("to_err",     32'(err), 1);
        check_eq("to_issued",  32'(issued), 0);
        check_eq("to_busy",    32'(busy), 0);
        check_eq("to_starts",  32'(start_total - s0), 1);
        stuck = 1'b0;
        @(negedge clk);
        check_eq("to_err_sticky", 32'(err), 1);
        start_batch(8'd0);
        check_eq("to_err_clear", 32'(err), 0);
        check_eq("to_clr_done",  32'(done), 1);
        @(negedge clk);

        // Reset while waiting for the responder; FIFO still holds leftover (1,1) pairs.
        start_batch(8'd1);
        k = 0;
        while (!mac_start && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("rm_start_seen", 32'(mac_start), 1);
        repeat (2) @(negedge clk);
        check_eq("rm_in_wait_high", 32'(mac_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rm_mac_start", 32'(mac_start), 0);
        check_eq("rm_mac_ab",    32'({mac_a, mac_b}), 0);
        check_eq("rm_busy",      32'(busy), 0);
        check_eq("rm_done",      32'(done), 0);
        check_eq("rm_result",    32'(result), 0);
        check_eq("rm_err",       32'(err), 0);
        check_eq("rm_issued",    32'(issued), 0);
        check_eq("rm_in_ready",  32'(in_ready), 1);

        // Only the fresh pair may issue, and only after the responder finishes
        // the abandoned 1*1, which lands inside this batch's window: 1 + 2*3.
        qb = ops_q.size();
        push_pair(8'd2, 8'd3);
        run_batch("rm_next", 8'd1, 16'h0007);
        check_eq("rm_nops",     32'(ops_q.size() - qb), 1);
        check_eq("rm_op",       32'(ops_q[qb]), 32'h0203);
        check_eq("no_busy_start", 32'(start_lowready), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Initiator side of the start/ready multiply-accumulate handshake.
- Buffers operand pairs in a small FIFO and issues them one at a time to a MAC responder (start pulse, operands held, wait for ready to fall then rise).
- Counts a commanded batch of operations and reports the batch sum as the difference of the MAC accumulator before and after the batch.
- Sits between a host/operand source and the MAC block.

Parameters:
- opsize, 8, operand width; result width is 2*opsize.
- DEPTH, 4, operand FIFO entries (power of 2, >=2).
- CNT_W, 8, width of batch length and issue counter.
- LOW_TIMEOUT, 4, cycles allowed for mac_ready to fall after mac_start.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO not full; push when in_valid && in_ready.
- in_a  in  opsize  operand A.
- in_b  in  opsize  operand B.
- go  in  1  start batch (sampled only in IDLE).
- batch_len  in  CNT_W  operations in batch, sampled with go.
- busy  out  1  batch in progress.
- done  out  1  one-cycle batch-complete pulse.
- result  out  2*opsize  batch sum, valid from done onward.
- err  out  1  sticky timeout flag, cleared by accepted go.
- issued  out  CNT_W  operations completed in current/last batch.
- mac_start  out  1  one-cycle start to responder.
- mac_a  out  opsize  operand A to responder.
- mac_b  out  opsize  operand B to responder.
- mac_ready  in  1  responder idle/complete.
- mac_out  in  2*opsize  responder accumulator.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high. Reset values: mac_start=0, mac_a=mac_b=0, busy=0, done=0, result=0, err=0, issued=0, FIFO empty, in_ready=1, state IDLE.
- All outputs are registered.
- FIFO:
  - Push is permitted in any state.
  - Pop happens only in FETCH.
  - in_ready=!full. On full, no push occurs even when a pop happens in the same cycle.
  - Simultaneous push and pop when not full: count is unchanged, order is preserved.
- IDLE:
  - go=1 with batch_len>0: capture base=mac_out, remaining=batch_len; clear issued and err; busy=1; go to FETCH.
  - go=1 with batch_len=0: next cycle done=1, result=0, issued=0, err cleared, no mac_start.
  - go while busy is ignored.
- FETCH: when FIFO is non-empty AND mac_ready=1, pop the head into mac_a/mac_b and go to ISSUE. Otherwise stall, which covers an empty FIFO or a responder still busy after reset.
- ISSUE: mac_start=1 for exactly this cycle; mac_a/mac_b are held stable until the operation completes. Clear the timer and go to WAIT_LOW.
- WAIT_LOW:
  - mac_ready=0: go to WAIT_HIGH.
  - Timer reaches LOW_TIMEOUT with mac_ready still 1: set err=1 and go to DONE (batch aborted, issued not incremented).
- WAIT_HIGH:
  - On mac_ready=1, the responder accumulator is already updated the same cycle.
  - issued+1, remaining-1.
  - remaining reaches 0: go to DONE; otherwise go to FETCH.
- DONE:
  - result = (mac_out - base) mod 2^(2*opsize).
  - done=1 for one cycle; busy=0 the same cycle.
  - Return to IDLE.
- Latency: with FIFO non-empty and mac_ready=1, mac_start is high 2 cycles after the go edge. Per-op overhead beyond responder latency is 2 cycles (FETCH, ISSUE).
- Reset mid-batch:
  - Batch is abandoned and the FIFO flushed.
  - The responder may still be computing. The next batch does not issue until mac_ready=1.
- issued wraps at 2^CNT_W. batch_len up to 2^CNT_W-1 is supported.

Test Plan:
- Normal batch: push (3,4),(5,6); go, batch_len=2; responder accumulator starts at 0. Required: two mac_start pulses with operands in push order, done, result=0x002A, issued=2.
- Second batch, same operands, no accumulator clear. Required: mac_out=0x0054 at end, result=0x002A.
- Wrap, opsize=8: push (255,255) twice, batch_len=2. Required: result=0xFC02 (130050 mod 65536).
- FIFO full, DEPTH=4, no go: offer 5 pairs. Required: in_ready=0 after the 4th push; 5th accepted one cycle after the first pop; all 5 consumed in order over a batch_len=5 batch.
- Timeout: responder model holds mac_ready=1 permanently; batch_len=3. Required: err=1 and done after LOW_TIMEOUT cycles in WAIT_LOW, issued=0, a single mac_start; err cleared by next go.
- Edge cases:
  - batch_len=0: done on the next cycle, result=0, no mac_start.
  - rst asserted while in WAIT_HIGH: all outputs at reset values next cycle, FIFO empty.
